// File: rtl/audio_clk_nco.sv
`default_nettype none
// ============================================================================
// Module  : audio_clk_nco
// Brief   : Fractional-NCO BCLK generator with slot/bit counters and
//           LJ / I2S / DSP-TDM frame sync; config swaps only at frame edges.
// Revision: 1.0  initial release
// ============================================================================
module audio_clk_nco #(
   parameter int ACC_W       = 24,
   parameter int SLOT_BITS   = 32,
   parameter int CHANNELS    = 2,
   parameter int LOCK_FRAMES = 4
) (
   input  logic                         refclk,
   input  logic                         rst,
   input  logic [ACC_W-1:0]             cfg_inc,
   input  logic [1:0]                   cfg_fmt,
   output logic                         bclk,
   output logic                         lrclk,
   output logic                         bclk_rise,
   output logic                         bclk_fall,
   output logic                         frame_start,
   output logic [$clog2(CHANNELS)-1:0]  slot_idx,
   output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
   output logic                         cfg_pending,
   output logic                         locked
);

   localparam int         c_SLOT_W  = $clog2(CHANNELS);
   localparam int         c_BIT_W   = $clog2(SLOT_BITS);
   localparam logic [1:0] c_FMT_I2S = 2'd1;
   localparam logic [1:0] c_FMT_DSP = 2'd2;

   logic [ACC_W-1:0]    acc_q;
   logic [ACC_W-1:0]    inc_a_q;
   logic [1:0]          fmt_a_q;
   logic                bclk_q;
   logic                lrclk_q;
   logic                lr0_prev_q;
   logic                rise_q;
   logic                fall_q;
   logic                fs_q;
   logic [c_SLOT_W-1:0] slot_q;
   logic [c_SLOT_W-1:0] slot_d;
   logic [c_BIT_W-1:0]  bit_q;
   logic [c_BIT_W-1:0]  bit_d;
   logic [7:0]          lock_cnt_q;

   logic [ACC_W:0]      w_sum;
   logic                w_tick;
   logic                w_frame_wrap;
   logic                w_lr0;
   logic                w_lr_d;
   logic                w_pending;
   logic                w_load;

   assign w_sum  = {1'b0, acc_q} + {1'b0, inc_a_q};
   assign w_tick = w_sum[ACC_W];

   // Post-advance counter values, committed only on a falling BCLK tick.
   always_comb begin
      bit_d        = bit_q + c_BIT_W'(1);
      slot_d       = slot_q;
      w_frame_wrap = 1'b0;
      if (bit_q == c_BIT_W'(SLOT_BITS - 1)) begin
         bit_d = '0;
         if (slot_q == c_SLOT_W'(CHANNELS - 1)) begin
            slot_d       = '0;
            w_frame_wrap = 1'b1;
         end else begin
            slot_d = slot_q + c_SLOT_W'(1);
         end
      end
   end

   // I2S reuses the left-justified level from the previous bit period.
   always_comb begin
      w_lr0 = (slot_d >= c_SLOT_W'(CHANNELS / 2));
      case (fmt_a_q)
         c_FMT_I2S: w_lr_d = lr0_prev_q;
         c_FMT_DSP: w_lr_d = (slot_d == '0) && (bit_d == '0);
         default:   w_lr_d = w_lr0;
      endcase
   end

   assign w_pending = (cfg_inc != inc_a_q) || (cfg_fmt != fmt_a_q);
   assign w_load    = w_pending && ((inc_a_q == '0) || fs_q);

   always_ff @(posedge refclk) begin
      if (rst) begin
         acc_q      <= '0;
         inc_a_q    <= '0;
         fmt_a_q    <= '0;
         bclk_q     <= 1'b0;
         lrclk_q    <= 1'b0;
         lr0_prev_q <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         fs_q       <= 1'b0;
         slot_q     <= '0;
         bit_q      <= '0;
         lock_cnt_q <= '0;
      end else begin
         acc_q  <= w_sum[ACC_W-1:0];
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         fs_q   <= 1'b0;
         if (w_tick) begin
            if (!bclk_q) begin
               bclk_q <= 1'b1;
               rise_q <= 1'b1;
            end else begin
               bclk_q     <= 1'b0;
               fall_q     <= 1'b1;
               bit_q      <= bit_d;
               slot_q     <= slot_d;
               fs_q       <= w_frame_wrap;
               lrclk_q    <= w_lr_d;
               lr0_prev_q <= w_lr0;
            end
         end
         if (w_load) begin
            inc_a_q    <= cfg_inc;
            fmt_a_q    <= cfg_fmt;
            lock_cnt_q <= '0;
         end else if (fs_q && (lock_cnt_q != 8'(LOCK_FRAMES))) begin
            lock_cnt_q <= lock_cnt_q + 8'd1;
         end
      end
   end

   assign bclk        = bclk_q;
   assign lrclk       = lrclk_q;
   assign bclk_rise   = rise_q;
   assign bclk_fall   = fall_q;
   assign frame_start = fs_q;
   assign slot_idx    = slot_q;
   assign bit_idx     = bit_q;
   assign cfg_pending = w_pending;
   assign locked      = (lock_cnt_q == 8'(LOCK_FRAMES)) && (inc_a_q != '0) && !w_pending;

endmodule
`default_nettype wire
